// File: rtl/instr_packer_pkg.sv
// Shared constants for the instruction packer: format tags, MIPS field
// positions (identical to the field splitter) and the default load address.
package instr_packer_pkg;

    // Format tags carried alongside each field tuple
    localparam logic [1:0] FMT_R   = 2'd0;
    localparam logic [1:0] FMT_I   = 2'd1;
    localparam logic [1:0] FMT_J   = 2'd2;
    localparam logic [1:0] FMT_ILL = 2'd3;

    // Field bit positions within the 32-bit instruction word
    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SH_HI    = 10;
    localparam int SH_LO    = 6;
    localparam int FN_HI    = 5;
    localparam int FN_LO    = 0;
    localparam int IMM16_HI = 15;
    localparam int IMM16_LO = 0;
    localparam int IMM26_HI = 25;
    localparam int IMM26_LO = 0;

    // IM byte address given to the first packed word after reset/clear
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_3000;

endpackage

// File: rtl/instr_packer_encode.sv
// Combinational packer: builds a 32-bit MIPS word from decoded fields and a
// format tag. Fields not used by the selected format are ignored.
module instr_packer_encode
    import instr_packer_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [5:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  func,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    output logic [31:0] word,
    output logic        legal
);

    // Place each field at its slot for the selected format
    always_comb begin
        word  = 32'd0;
        legal = 1'b1;
        case (fmt)
            FMT_R: begin
                word[OP_HI:OP_LO] = op;
                word[RS_HI:RS_LO] = rs;
                word[RT_HI:RT_LO] = rt;
                word[RD_HI:RD_LO] = rd;
                word[SH_HI:SH_LO] = shamt;
                word[FN_HI:FN_LO] = func;
            end
            FMT_I: begin
                word[OP_HI:OP_LO]       = op;
                word[RS_HI:RS_LO]       = rs;
                word[RT_HI:RT_LO]       = rt;
                word[IMM16_HI:IMM16_LO] = imm16;
            end
            FMT_J: begin
                word[OP_HI:OP_LO]       = op;
                word[IMM26_HI:IMM26_LO] = imm26;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_packer.sv
// Instruction packer: accepts field tuples over a valid/ready stream, packs
// them into instruction words and emits each with its IM byte address.
// Tracks a word count against DEPTH and stops accepting once it is reached.
module instr_packer
    import instr_packer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          DEPTH     = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  fmt,
    input  logic [5:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  func,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        full,
    output logic        done,
    output logic        err
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      word;
    logic             legal;
    logic             accept;
    logic             out_valid_reg;
    logic [31:0]      out_instr_reg;
    logic [31:0]      out_addr_reg;
    logic [31:0]      addr_cnt_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             full_reg;
    logic             err_reg;

    instr_packer_encode u_encode (
        .fmt   (fmt),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .rd    (rd),
        .shamt (shamt),
        .func  (func),
        .imm16 (imm16),
        .imm26 (imm26),
        .word  (word),
        .legal (legal)
    );

    // Room for a new tuple when not full and the output slot is free or draining
    assign in_ready = !full_reg && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;

    // Output register, address/count tracking and error pulse
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            out_valid_reg <= 1'b0;
            out_instr_reg <= 32'd0;
            out_addr_reg  <= 32'd0;
            addr_cnt_reg  <= BASE_ADDR;
            cnt_reg       <= '0;
            full_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            err_reg <= accept && !legal;
            if (accept && legal) begin
                out_valid_reg <= 1'b1;
                out_instr_reg <= word;
                out_addr_reg  <= addr_cnt_reg;
                addr_cnt_reg  <= addr_cnt_reg + 32'd4;
                cnt_reg       <= cnt_reg + 1'b1;
                // Full takes effect together with the count reaching DEPTH
                if (cnt_reg == CNT_W'(DEPTH - 1)) begin
                    full_reg <= 1'b1;
                end
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_instr = out_instr_reg;
    assign out_addr  = out_addr_reg;
    assign full      = full_reg;
    assign done      = full_reg && !out_valid_reg;
    assign err       = err_reg;

endmodule
